reg8_write_ctrl: RTL and testbench

// - Writer side of the 8-bit register bank: feeds the EN/D write port of up to NREGS reg8bits instances.
// - Accepts write requests (addr, data) over valid/ready and buffers them in a DEPTH-entry FIFO.
// - Issues at most one write per cycle as a one-hot EN strobe plus a shared D bus.
// - Sits between datapath write-back and the register bank; provides stall and flush.

---
 rtl/reg8_write_ctrl_if.sv | 35 +++
 rtl/reg8_write_ctrl.sv | 148 ++++++++++++++
 tb/tb_reg8_write_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg8_write_ctrl_if.sv
// reg8_write_ctrl_if
// Request and register-bank bundle for reg8_write_ctrl.
//   master : the producer side, which drives requests, stall and flush and
//            observes the bank write port and the status outputs
//   slave  : reg8_write_ctrl itself
// Signals:
//   req_valid/req_ready/req_addr/req_data : write request handshake
//   stall, flush                          : issue hold / queue discard
//   EN (NREGS), D (8)                     : one-hot write strobe and shared data bus
//   busy, wr_count (8)                    : status
interface reg8_write_ctrl_if #(
    parameter int NREGS = 8,
    parameter int AW    = 3
);
    logic             req_valid;
    logic             req_ready;
    logic [AW-1:0]    req_addr;
    logic [7:0]       req_data;
    logic             stall;
    logic             flush;
    logic [NREGS-1:0] EN;
    logic [7:0]       D;
    logic             busy;
    logic [7:0]       wr_count;

    modport master (
        output req_valid, req_addr, req_data, stall, flush,
        input  req_ready, EN, D, busy, wr_count
    );

    modport slave (
        input  req_valid, req_addr, req_data, stall, flush,
        output req_ready, EN, D, busy, wr_count
    );
endinterface

// File: rtl/reg8_write_ctrl.sv
// reg8_write_ctrl
// Writer side of the 8-bit register bank. Write requests (addr, data) are
// accepted over valid/ready into a DEPTH-entry FIFO and issued at most one
// per cycle as a registered one-hot EN strobe with a shared registered D bus.
// Requests with addr >= NREGS are accepted and popped but never strobed.
//
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : reg8_write_ctrl_if.slave (req_*, stall, flush, EN, D, busy, wr_count)
//
// Parameters: NREGS (EN width), AW (address width), DEPTH (FIFO entries,
// power of two, >= 2).
//
// Optional feature: define REG8_WRITE_MERGE_EN to let a push whose address
// matches the tail entry overwrite the tail data instead of allocating.
module reg8_write_ctrl #(
    parameter int NREGS = 8,
    parameter int AW    = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    reg8_write_ctrl_if.slave bus
);
    localparam int AWF = $clog2(DEPTH);
    localparam int CW  = AWF + 1;
    localparam logic [NREGS-1:0] EN_LSB = {{(NREGS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic [AWF-1:0]   rptr;
    logic [AWF-1:0]   wptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [AW-1:0]    mem_addr [DEPTH];
    logic [7:0]       mem_data [DEPTH];
    logic [AW-1:0]    head_addr;
    logic [7:0]       head_data;
    logic             head_in_range;
    logic             push;
    logic             pop;
    logic             merge;
    logic             alloc;
    logic [NREGS-1:0] en_q;
    logic [7:0]       d_q;
    logic [7:0]       wr_count_q;

    assign head_addr     = mem_addr[rptr];
    assign head_data     = mem_data[rptr];
    assign head_in_range = int'(head_addr) < NREGS;

    // The queue is only non-empty outside IDLE, so gating on the state keeps
    // the FSM authoritative; HOLD pops as soon as stall drops, so there is
    // no bubble between a stall release and the first strobe.
    assign pop = (state != IDLE) && (count != '0) && !bus.stall && !bus.flush;

`ifdef REG8_WRITE_MERGE_EN
    logic [AWF-1:0] tail_ptr;
    logic           tail_hit;

    // A tail that is also the head being popped this cycle cannot be merged
    // into, since its data is already on its way to the D register.
    assign tail_ptr = wptr - AWF'(1);
    assign tail_hit = (count != '0) && (mem_addr[tail_ptr] == bus.req_addr)
                      && !(pop && (count == CW'(1)));
    assign bus.req_ready = ((count < CW'(DEPTH)) || tail_hit) && !bus.flush && !rst;
    assign merge         = push && tail_hit;
`else
    assign bus.req_ready = (count < CW'(DEPTH)) && !bus.flush && !rst;
    assign merge         = 1'b0;
`endif

    assign push       = bus.req_valid && bus.req_ready;
    assign alloc      = push && !merge;
    assign count_next = count + CW'(alloc) - CW'(pop);

    // FIFO storage carries no reset; validity is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (alloc) begin
            mem_addr[wptr] <= bus.req_addr;
            mem_data[wptr] <= bus.req_data;
        end
`ifdef REG8_WRITE_MERGE_EN
        else if (merge) begin
            mem_data[tail_ptr] <= bus.req_data;
        end
`endif
    end

    // Control FSM with pointers, count and the registered bank outputs.
    // An EN strobe lasts exactly one cycle because it is cleared every edge
    // unless a new in-range entry is popped; flush clears only what is
    // queued, so a strobe already on the bus completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rptr       <= '0;
            wptr       <= '0;
            count      <= '0;
            en_q       <= '0;
            d_q        <= '0;
            wr_count_q <= '0;
        end else begin
            en_q <= '0;
            if (pop && head_in_range) begin
                en_q       <= EN_LSB << head_addr;
                d_q        <= head_data;
                wr_count_q <= wr_count_q + 8'd1;
            end

            if (bus.flush) begin
                rptr  <= '0;
                wptr  <= '0;
                count <= '0;
            end else begin
                if (alloc) begin
                    wptr <= wptr + AWF'(1);
                end
                if (pop) begin
                    rptr <= rptr + AWF'(1);
                end
                count <= count_next;
            end

            if (bus.flush) begin
                state <= IDLE;
            end else if (bus.stall && ((count != '0) || alloc)) begin
                state <= HOLD;
            end else if (count_next != '0) begin
                state <= ISSUE;
            end else begin
                state <= IDLE;
            end
        end
    end

    assign bus.EN       = en_q;
    assign bus.D        = d_q;
    assign bus.wr_count = wr_count_q;
    assign bus.busy     = (count != '0) || (|en_q);

endmodule

// File: tb/tb_reg8_write_ctrl.sv
// tb_reg8_write_ctrl
// Self-checking bench for reg8_write_ctrl (NREGS=8, DEPTH=4) plus a second
// instance with NREGS=6 for the out-of-range drop case. Expected values come
// from a transaction-level queue model of the request stream.
// Define REG8_WRITE_MERGE_EN to exercise the tail-merge build.
module tb_reg8_write_ctrl;
    localparam int NREGS = 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg8_write_ctrl_if #(.NREGS(8), .AW(3)) bus ();
    reg8_write_ctrl_if #(.NREGS(6), .AW(3)) bus6 ();

    reg8_write_ctrl #(.NREGS(8), .AW(3), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    reg8_write_ctrl #(.NREGS(6), .AW(3), .DEPTH(4)) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (bus6)
    );

    int         checks   = 0;
    int         failures = 0;
    req_t       q[$];
    logic [7:0] exp_en;
    logic [7:0] exp_d;
    logic [7:0] exp_wr;
    logic       exp_ready;
    logic       obs_ready;

    function automatic logic exp_busy();
        return (q.size() > 0) || (exp_en != 8'h00);
    endfunction

    task automatic model_reset();
        q.delete();
        exp_en = 8'h00;
        exp_d  = 8'h00;
        exp_wr = 8'h00;
    endtask

    // Drives one cycle of inputs, samples req_ready mid-cycle, advances the
    // queue model across the edge and returns #1 after it.
    task automatic cycle(input logic v, input logic [2:0] a, input logic [7:0] d,
                         input logic s, input logic f);
        logic pop_now;
        logic merge_ok;
        logic acc;
        req_t e;
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.req_data  = d;
        bus.stall     = s;
        bus.flush     = f;
        pop_now  = !f && !s && (q.size() > 0);
        merge_ok = 1'b0;
`ifdef REG8_WRITE_MERGE_EN
        if (q.size() > 0) begin
            if (q[q.size()-1].addr == a && !(pop_now && q.size() == 1)) merge_ok = 1'b1;
        end
`endif
        exp_ready = ((q.size() < DEPTH) || merge_ok) && !f;
        acc       = v && exp_ready;
        @(negedge clk);
        obs_ready = bus.req_ready;
        @(posedge clk);
        exp_en = 8'h00;
        if (f) begin
            q.delete();
        end else begin
            if (pop_now) begin
                e = q.pop_front();
                if (int'(e.addr) < NREGS) begin
                    exp_en = 8'h01 << e.addr;
                    exp_d  = e.data;
                    exp_wr = exp_wr + 8'd1;
                end
            end
            if (acc) begin
                e.addr = a;
                e.data = d;
                if (merge_ok) q[q.size()-1] = e;
                else          q.push_back(e);
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ($countones(bus.EN) > 1 || $countones(bus6.EN) > 1) begin
                failures++;
                $display("[TB] FAIL en_onehot: EN=%b EN6=%b, required at most one bit set", bus.EN, bus6.EN);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 0; bus.req_addr = 0; bus.req_data = 0; bus.stall = 0; bus.flush = 0;
        bus6.req_valid = 0; bus6.req_addr = 0; bus6.req_data = 0; bus6.stall = 0; bus6.flush = 0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        checks++; if (bus.EN !== 8'h00)      begin failures++; $display("[TB] FAIL reset_en: got %h want 00", bus.EN); end
        checks++; if (bus.D !== 8'h00)       begin failures++; $display("[TB] FAIL reset_d: got %h want 00", bus.D); end
        checks++; if (bus.wr_count !== 8'h00) begin failures++; $display("[TB] FAIL reset_wr_count: got %h want 00", bus.wr_count); end
        checks++; if (bus.busy !== 1'b0)     begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready_in_rst: got %b want 0", bus.req_ready); end
        rst = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready_after: got %b want 1", bus.req_ready); end
    endtask

    task automatic test_single();
        cycle(1'b1, 3'd3, 8'hA5, 1'b0, 1'b0);
        checks++; if (obs_ready !== 1'b1) begin failures++; $display("[TB] FAIL single_ready: got %b want 1", obs_ready); end
        checks++; if (bus.EN !== 8'h00)   begin failures++; $display("[TB] FAIL single_no_bypass: got EN=%h want 00", bus.EN); end
        checks++; if (bus.busy !== 1'b1)  begin failures++; $display("[TB] FAIL single_busy_queued: got %b want 1", bus.busy); end
        cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        checks++; if (bus.EN !== 8'b0000_1000) begin failures++; $display("[TB] FAIL single_en: got %b want 00001000", bus.EN); end
        checks++; if (bus.D !== 8'hA5)         begin failures++; $display("[TB] FAIL single_d: got %h want a5", bus.D); end
        checks++; if (bus.wr_count !== 8'd1)   begin failures++; $display("[TB] FAIL single_wr_count: got %0d want 1", bus.wr_count); end
        cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        checks++; if (bus.EN !== 8'h00)  begin failures++; $display("[TB] FAIL single_en_one_cycle: got %h want 00", bus.EN); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_done: got %b want 0", bus.busy); end
    endtask

    task automatic test_stall_fill();
        logic [2:0] a [5];
        logic [7:0] d [5];
        logic [2:0] base;
        logic       want_r;
        logic [7:0] want_en;
        base = 3'($urandom_range(0, 7));
        for (int i = 0; i < 5; i++) begin
            a[i] = base + 3'(i);
            d[i] = 8'($urandom);
            cycle(1'b1, a[i], d[i], 1'b1, 1'b0);
            want_r = (i < 4);
            checks++;
            if (obs_ready !== want_r) begin failures++; $display("[TB] FAIL stall_fill_ready[%0d]: got %b want %b", i, obs_ready, want_r); end
            checks++;
            if (bus.EN !== 8'h00) begin failures++; $display("[TB] FAIL stall_fill_no_issue[%0d]: got %h want 00", i, bus.EN); end
        end
        for (int j = 0; j < 5; j++) begin
            cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
            want_en = (j < 4) ? (8'h01 << a[j]) : 8'h00;
            checks++;
            if (bus.EN !== want_en) begin failures++; $display("[TB] FAIL stall_drain_en[%0d]: got %b want %b", j, bus.EN, want_en); end
            if (j < 4) begin
                checks++;
                if (bus.D !== d[j]) begin failures++; $display("[TB] FAIL stall_drain_d[%0d]: got %h want %h", j, bus.D, d[j]); end
            end
        end
    endtask

    task automatic test_flush();
        cycle(1'b1, 3'd0, 8'h31, 1'b1, 1'b0);
        cycle(1'b1, 3'd4, 8'h32, 1'b1, 1'b0);
        cycle(1'b1, 3'd2, 8'h5A, 1'b1, 1'b1);
        checks++; if (obs_ready !== 1'b0) begin failures++; $display("[TB] FAIL flush_ready: got %b want 0", obs_ready); end
        checks++; if (bus.busy !== 1'b0)  begin failures++; $display("[TB] FAIL flush_busy: got %b want 0", bus.busy); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
            checks++;
            if (bus.EN !== 8'h00) begin failures++; $display("[TB] FAIL flush_no_en[%0d]: got %h want 00", i, bus.EN); end
            checks++;
            if (bus.wr_count !== exp_wr) begin failures++; $display("[TB] FAIL flush_wr_count[%0d]: got %0d want %0d", i, bus.wr_count, exp_wr); end
        end
    endtask

    task automatic test_merge();
        int         n;
        logic [7:0] seen [4];
        n = 0;
        cycle(1'b1, 3'd1, 8'h11, 1'b1, 1'b0);
        cycle(1'b1, 3'd1, 8'h22, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
            if (bus.EN != 8'h00) begin
                checks++;
                if (bus.EN !== 8'h02) begin failures++; $display("[TB] FAIL merge_en: got %b want 00000010", bus.EN); end
                if (n < 4) seen[n] = bus.D;
                n++;
            end
        end
`ifdef REG8_WRITE_MERGE_EN
        checks++; if (n != 1) begin failures++; $display("[TB] FAIL merge_strobes: got %0d want 1", n); end
        if (n >= 1) begin
            checks++; if (seen[0] !== 8'h22) begin failures++; $display("[TB] FAIL merge_d: got %h want 22", seen[0]); end
        end
`else
        checks++; if (n != 2) begin failures++; $display("[TB] FAIL nomerge_strobes: got %0d want 2", n); end
        if (n >= 2) begin
            checks++; if (seen[0] !== 8'h11) begin failures++; $display("[TB] FAIL nomerge_d0: got %h want 11", seen[0]); end
            checks++; if (seen[1] !== 8'h22) begin failures++; $display("[TB] FAIL nomerge_d1: got %h want 22", seen[1]); end
        end
`endif
    endtask

    task automatic test_random();
        logic       v, s, f;
        logic [2:0] a;
        logic [7:0] d;
        for (int i = 0; i < 306; i++) begin
            if (i < 300) begin
                v = ($urandom_range(0, 3) != 0);
                a = 3'($urandom_range(0, 7));
                d = 8'($urandom);
                s = ($urandom_range(0, 3) == 0);
                f = ($urandom_range(0, 19) == 0);
            end else begin
                v = 1'b0; a = 3'd0; d = 8'h00; s = 1'b0; f = 1'b0;
            end
            cycle(v, a, d, s, f);
            checks++;
            if (obs_ready !== exp_ready) begin failures++; $display("[TB] FAIL rand_ready[%0d]: got %b want %b", i, obs_ready, exp_ready); end
            checks++;
            if (bus.EN !== exp_en) begin failures++; $display("[TB] FAIL rand_en[%0d]: got %b want %b", i, bus.EN, exp_en); end
            checks++;
            if (bus.D !== exp_d) begin failures++; $display("[TB] FAIL rand_d[%0d]: got %h want %h", i, bus.D, exp_d); end
            checks++;
            if (bus.wr_count !== exp_wr) begin failures++; $display("[TB] FAIL rand_wr_count[%0d]: got %0d want %0d", i, bus.wr_count, exp_wr); end
            checks++;
            if (bus.busy !== exp_busy()) begin failures++; $display("[TB] FAIL rand_busy[%0d]: got %b want %b", i, bus.busy, exp_busy()); end
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 3'd4, 8'h44, 1'b1, 1'b0);
        cycle(1'b1, 3'd5, 8'h55, 1'b1, 1'b0);
        cycle(1'b1, 3'd6, 8'h66, 1'b1, 1'b0);
        cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        checks++; if (bus.EN !== 8'h10) begin failures++; $display("[TB] FAIL rstmid_first_en: got %b want 00010000", bus.EN); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        checks++; if (bus.EN !== 8'h00)       begin failures++; $display("[TB] FAIL rstmid_en: got %h want 00", bus.EN); end
        checks++; if (bus.D !== 8'h00)        begin failures++; $display("[TB] FAIL rstmid_d: got %h want 00", bus.D); end
        checks++; if (bus.wr_count !== 8'h00) begin failures++; $display("[TB] FAIL rstmid_wr_count: got %0d want 0", bus.wr_count); end
        rst = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_ready: got %b want 1", bus.req_ready); end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
            checks++;
            if (bus.EN !== 8'h00) begin failures++; $display("[TB] FAIL rstmid_no_en[%0d]: got %h want 00", i, bus.EN); end
        end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 256; i++) begin
            cycle(1'b1, 3'd0, 8'(i), 1'b0, 1'b0);
        end
        repeat (3) cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        checks++; if (bus.wr_count !== 8'd0) begin failures++; $display("[TB] FAIL wrap_wr_count: got %0d want 0", bus.wr_count); end
        cycle(1'b1, 3'd7, 8'h7E, 1'b0, 1'b0);
        cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        checks++; if (bus.EN !== 8'h80)      begin failures++; $display("[TB] FAIL top_index_en: got %b want 10000000", bus.EN); end
        checks++; if (bus.D !== 8'h7E)       begin failures++; $display("[TB] FAIL top_index_d: got %h want 7e", bus.D); end
        checks++; if (bus.wr_count !== 8'd1) begin failures++; $display("[TB] FAIL top_index_wr_count: got %0d want 1", bus.wr_count); end
    endtask

    task automatic test_nregs6();
        bus6.req_valid = 1'b1;
        bus6.req_addr  = 3'd7;
        bus6.req_data  = 8'h33;
        @(negedge clk);
        checks++; if (bus6.req_ready !== 1'b1) begin failures++; $display("[TB] FAIL n6_ready: got %b want 1", bus6.req_ready); end
        @(posedge clk);
        #1;
        bus6.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus6.EN !== 6'b000000) begin failures++; $display("[TB] FAIL n6_drop_en[%0d]: got %b want 000000", i, bus6.EN); end
        end
        checks++; if (bus6.wr_count !== 8'd0) begin failures++; $display("[TB] FAIL n6_drop_wr_count: got %0d want 0", bus6.wr_count); end
        checks++; if (bus6.busy !== 1'b0)     begin failures++; $display("[TB] FAIL n6_drop_busy: got %b want 0", bus6.busy); end
        bus6.req_valid = 1'b1;
        bus6.req_addr  = 3'd5;
        bus6.req_data  = 8'h44;
        @(posedge clk);
        #1;
        bus6.req_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus6.EN !== 6'b100000)  begin failures++; $display("[TB] FAIL n6_top_en: got %b want 100000", bus6.EN); end
        checks++; if (bus6.D !== 8'h44)       begin failures++; $display("[TB] FAIL n6_top_d: got %h want 44", bus6.D); end
        checks++; if (bus6.wr_count !== 8'd1) begin failures++; $display("[TB] FAIL n6_top_wr_count: got %0d want 1", bus6.wr_count); end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_single();
        test_stall_fill();
        test_flush();
        test_merge();
        test_random();
        test_reset_mid();
        test_wrap();
        test_nregs6();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
